// File: rtl/usb_tx_sched_if.sv
// usb_tx_sched_if: request/grant and TX-module signals of the USB TX scheduler.
// The scheduler takes the slave view; requesters and the TX module take the master view.
interface usb_tx_sched_if;
   logic       hs_req;
   logic [1:0] hs_pid;
   logic       hs_grant;
   logic       data_req;
   logic       data_grant;
   logic       stall_en;
   logic [6:0] buffer_occupancy;
   logic       tx_transfer_active;
   logic       tx_error;
   logic       tx_start;
   logic [1:0] tx_packet;
   logic       busy;
   logic       done;
   logic       fail;

   modport master (
      output hs_req, hs_pid, data_req, stall_en, buffer_occupancy,
             tx_transfer_active, tx_error,
      input  hs_grant, data_grant, tx_start, tx_packet, busy, done, fail
   );

   modport slave (
      input  hs_req, hs_pid, data_req, stall_en, buffer_occupancy,
             tx_transfer_active, tx_error,
      output hs_grant, data_grant, tx_start, tx_packet, busy, done, fail
   );
endinterface

// File: rtl/usb_tx_sched.sv
// usb_tx_sched: arbitrates handshake and DATA0 requests onto the USB TX path,
// inserts the inter-packet gap, supervises the transfer and reports done/fail.
module usb_tx_sched #(
   parameter int GAP_CYCLES     = 16,
   parameter int TIMEOUT_CYCLES = 32,
   parameter int CNT_W          = 6
) (
   input  logic           clk,
   input  logic           n_rst,
   usb_tx_sched_if.slave  bus
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_GAP,
      ST_START,
      ST_WAIT_ACT,
      ST_ACTIVE,
      ST_FIN
   } state_t;

   typedef enum logic [1:0] {
      PKT_DATA0 = 2'd0,
      PKT_ACK   = 2'd1,
      PKT_NAK   = 2'd2,
      PKT_STALL = 2'd3
   } pkt_t;

   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   // The shared counter must reach both terminal counts without saturating early.
   if (((1 << CNT_W) <= GAP_CYCLES) || ((1 << CNT_W) <= TIMEOUT_CYCLES)) begin : g_cnt_w_check
      $error("usb_tx_sched: CNT_W too narrow for GAP_CYCLES/TIMEOUT_CYCLES");
   end

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_err_seen;
   pkt_t             r_pkt;

   state_t           w_state_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [CNT_W-1:0] w_cnt_inc;
   logic             w_err_nxt;
   pkt_t             w_pkt_nxt;
   logic             w_hs_grant;
   logic             w_data_grant;
   logic             w_tx_start;
   logic             w_done;
   logic             w_fail;

   // Saturating increment: the counter holds at all-ones instead of wrapping.
   assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

   // State, counter, error flag and latched packet type.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_err_seen <= 1'b0;
         r_pkt      <= PKT_NAK;
      end else begin
         // NOTE: non-blocking so every register samples the pre-edge values computed below.
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_err_seen <= w_err_nxt;
         r_pkt      <= w_pkt_nxt;
      end
   end

   // Next-state logic, arbitration and the one-cycle output pulses.
   always_comb begin
      // NOTE: every target gets a default first so no path leaves one unassigned (no latches).
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_err_nxt    = r_err_seen;
      w_pkt_nxt    = r_pkt;
      w_hs_grant   = 1'b0;
      w_data_grant = 1'b0;
      w_tx_start   = 1'b0;
      w_done       = 1'b0;
      w_fail       = 1'b0;

      unique case (r_state)
         ST_IDLE: begin
            if (bus.hs_req) begin
               w_hs_grant  = 1'b1;
               w_pkt_nxt   = (bus.hs_pid == 2'd0) ? PKT_NAK : pkt_t'(bus.hs_pid);
               w_cnt_nxt   = '0;
               w_err_nxt   = 1'b0;
               w_state_nxt = ST_GAP;
            end else if (bus.data_req) begin
               w_data_grant = 1'b1;
               if (bus.stall_en)
                  w_pkt_nxt = PKT_STALL;
               else if (bus.buffer_occupancy == 7'd0)
                  w_pkt_nxt = PKT_NAK;
               else
                  w_pkt_nxt = PKT_DATA0;
               w_cnt_nxt   = '0;
               w_err_nxt   = 1'b0;
               w_state_nxt = ST_GAP;
            end
         end
         ST_GAP: begin
            if (r_cnt == GAP_LAST) begin
               w_cnt_nxt   = '0;
               w_state_nxt = ST_START;
            end else begin
               w_cnt_nxt = w_cnt_inc;
            end
         end
         ST_START: begin
            w_tx_start  = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = ST_WAIT_ACT;
         end
         ST_WAIT_ACT: begin
            if (bus.tx_error)
               w_err_nxt = 1'b1;
            if (bus.tx_transfer_active) begin
               w_state_nxt = ST_ACTIVE;
            end else if (r_cnt == TMO_LAST) begin
               w_fail      = 1'b1;
               w_state_nxt = ST_IDLE;
            end else begin
               w_cnt_nxt = w_cnt_inc;
            end
         end
         ST_ACTIVE: begin
            if (bus.tx_error)
               w_err_nxt = 1'b1;
            if (!bus.tx_transfer_active)
               w_state_nxt = ST_FIN;
         end
         ST_FIN: begin
            w_done      = !r_err_seen;
            w_fail      = r_err_seen;
            w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign bus.hs_grant   = w_hs_grant;
   assign bus.data_grant = w_data_grant;
   assign bus.tx_start   = w_tx_start;
   assign bus.tx_packet  = r_pkt;
   assign bus.busy       = (r_state != ST_IDLE);
   assign bus.done       = w_done;
   assign bus.fail       = w_fail;

endmodule

// File: tb/tb_usb_tx_sched.sv
// tb_usb_tx_sched: directed and randomized transactions checked against a
// timeline model of the scheduler (grant, start, end-of-packet cycles).
module tb_usb_tx_sched;

   localparam int GAP = 16;
   localparam int TMO = 32;

   logic clk = 1'b0;
   logic n_rst;
   int   total = 0;
   int   bad   = 0;

   usb_tx_sched_if bus();

   usb_tx_sched #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO), .CNT_W(6)) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Hard stop in case something loops unexpectedly.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.hs_req             = 1'b0;
      bus.hs_pid             = 2'd0;
      bus.data_req           = 1'b0;
      bus.stall_en           = 1'b0;
      bus.buffer_occupancy   = 7'd0;
      bus.tx_transfer_active = 1'b0;
      bus.tx_error           = 1'b0;
   endtask

   function automatic logic [5:0] pulse_vec();
      return {bus.hs_grant, bus.data_grant, bus.tx_start, bus.busy, bus.done, bus.fail};
   endfunction

   // Packet type the scheduler must latch for a request.
   function automatic logic [1:0] exp_pkt(input bit use_hs, input logic [1:0] pid,
                                          input bit stall, input logic [6:0] occ);
      if (use_hs) return (pid == 2'd0) ? 2'd2 : pid;
      if (stall) return 2'd3;
      if (occ == 7'd0) return 2'd2;
      return 2'd0;
   endfunction

   // Reset asserted mid-transaction: outputs must drop to reset values with no pulses.
   task automatic reset_abort(input string name);
      int pulses;
      n_rst = 1'b0;
      idle_inputs();
      #1;
      total++;
      if (pulse_vec() !== 6'b0 || bus.tx_packet !== 2'd2) begin
         bad++;
         $display("FAIL %s reset outputs: got flags=%b pkt=%0d, want flags=000000 pkt=2",
                  name, pulse_vec(), bus.tx_packet);
      end
      pulses = 0;
      repeat (3) begin
         next_cycle();
         @(negedge clk);
         if (pulse_vec() !== 6'b0) pulses++;
      end
      next_cycle();
      n_rst = 1'b1;
      @(negedge clk);
      if (pulse_vec() !== 6'b0) pulses++;
      total++;
      if (pulses != 0) begin
         bad++;
         $display("FAIL %s after reset: %0d cycles with outputs active, want 0", name, pulses);
      end
   endtask

   // One transaction. Cycle 0 is the grant cycle; active rises d cycles after
   // tx_start and stays for len cycles (never, if d > TMO). err_off >= 0 pulses
   // tx_error d+err_off cycles after tx_start. abort_at > 0 asserts reset at that cycle.
   task automatic do_txn(input string name, input bit use_hs, input bit also_data,
                         input logic [1:0] pid, input bit stall, input logic [6:0] occ,
                         input int d, input int len, input int err_off, input int abort_at,
                         output int wait_cyc);
      logic [1:0] pkt_exp, obs_pkt;
      int  s_exp, end_exp;
      bit  tmo, fail_exp, got;
      int  n_start, n_done, n_fail, n_grant, obs_start, obs_end, pkt_bad, busy_bad, both;

      pkt_exp  = exp_pkt(use_hs, pid, stall, occ);
      s_exp    = GAP + 1;
      tmo      = (d > TMO);
      fail_exp = tmo || (err_off >= 0);
      end_exp  = tmo ? s_exp + TMO : s_exp + d + len + 1;
      n_start = 0; n_done = 0; n_fail = 0; n_grant = 0;
      obs_start = -1; obs_end = -1; obs_pkt = 2'd0;
      pkt_bad = 0; busy_bad = 0; both = 0;

      next_cycle();
      if (use_hs) begin
         bus.hs_req = 1'b1;
         bus.hs_pid = pid;
      end
      if (!use_hs || also_data) begin
         bus.data_req         = 1'b1;
         bus.stall_en         = stall;
         bus.buffer_occupancy = occ;
      end
      wait_cyc = 0;
      @(negedge clk);
      got = use_hs ? bus.hs_grant : bus.data_grant;
      while (!got && wait_cyc < 100) begin
         next_cycle();
         @(negedge clk);
         wait_cyc++;
         got = use_hs ? bus.hs_grant : bus.data_grant;
      end
      total++;
      if (!got) begin
         bad++;
         $display("FAIL %s grant: not seen within %0d cycles", name, wait_cyc);
         idle_inputs();
         return;
      end
      total++;
      if (bus.hs_grant && bus.data_grant) begin
         bad++;
         $display("FAIL %s grant: hs_grant=1 data_grant=1 together, want one", name);
      end

      for (int c = 1; c <= end_exp; c++) begin
         next_cycle();
         if (c == 1) begin
            bus.hs_req = 1'b0;
            bus.hs_pid = 2'($urandom_range(0, 3));
            if (!also_data) begin
               bus.data_req         = 1'b0;
               bus.stall_en         = 1'($urandom_range(0, 1));
               bus.buffer_occupancy = 7'($urandom_range(0, 127));
            end
         end
         bus.tx_transfer_active = !tmo && (c >= s_exp + d) && (c < s_exp + d + len);
         bus.tx_error           = (err_off >= 0) && (c == s_exp + d + err_off);
         if (c == abort_at) begin
            reset_abort(name);
            return;
         end
         @(negedge clk);
         if (bus.tx_start) begin
            n_start++;
            obs_start = c;
            obs_pkt   = bus.tx_packet;
         end
         if (bus.done) begin n_done++; obs_end = c; end
         if (bus.fail) begin n_fail++; obs_end = c; end
         if (bus.done && bus.fail) both++;
         if (bus.hs_grant || bus.data_grant) n_grant++;
         if (bus.tx_packet !== pkt_exp) pkt_bad++;
         if (bus.busy !== 1'b1) busy_bad++;
      end
      bus.tx_error = 1'b0;

      total++;
      if (n_start != 1 || obs_start != s_exp) begin
         bad++;
         $display("FAIL %s tx_start: got %0d pulses last at %0d, want 1 at %0d",
                  name, n_start, obs_start, s_exp);
      end
      total++;
      if (obs_pkt !== pkt_exp) begin
         bad++;
         $display("FAIL %s tx_packet at start: got %0d want %0d", name, obs_pkt, pkt_exp);
      end
      total++;
      if (n_done != (fail_exp ? 0 : 1) || n_fail != (fail_exp ? 1 : 0)) begin
         bad++;
         $display("FAIL %s outcome: got done=%0d fail=%0d, want done=%0d fail=%0d",
                  name, n_done, n_fail, fail_exp ? 0 : 1, fail_exp ? 1 : 0);
      end
      total++;
      if (obs_end != end_exp) begin
         bad++;
         $display("FAIL %s end cycle: got %0d want %0d", name, obs_end, end_exp);
      end
      total++;
      if (n_grant != 0 || both != 0) begin
         bad++;
         $display("FAIL %s stray pulses: got grants=%0d done&fail=%0d, want 0 and 0",
                  name, n_grant, both);
      end
      total++;
      if (pkt_bad != 0 || busy_bad != 0) begin
         bad++;
         $display("FAIL %s hold: got %0d cycles pkt off and %0d cycles busy low, want 0 and 0",
                  name, pkt_bad, busy_bad);
      end
   endtask

   task automatic test_reset();
      n_rst = 1'b0;
      idle_inputs();
      repeat (3) next_cycle();
      @(negedge clk);
      total++;
      if (pulse_vec() !== 6'b0 || bus.tx_packet !== 2'd2) begin
         bad++;
         $display("FAIL reset values: got flags=%b pkt=%0d, want flags=000000 pkt=2",
                  pulse_vec(), bus.tx_packet);
      end
      next_cycle();
      n_rst = 1'b1;
      @(negedge clk);
      total++;
      if (pulse_vec() !== 6'b0 || bus.tx_packet !== 2'd2) begin
         bad++;
         $display("FAIL idle after reset: got flags=%b pkt=%0d, want flags=000000 pkt=2",
                  pulse_vec(), bus.tx_packet);
      end
   endtask

   task automatic test_hs_basic();
      int w;
      // Active at cycles 20..40: tx_start 17, done 42.
      do_txn("hs_ack", 1'b1, 1'b0, 2'd1, 1'b0, 7'd0, 3, 21, -1, -1, w);
      next_cycle();
      @(negedge clk);
      total++;
      if (bus.busy !== 1'b0) begin
         bad++;
         $display("FAIL hs_ack busy after FIN: got %b want 0", bus.busy);
      end
   endtask

   task automatic test_priority();
      int w;
      do_txn("prio_hs", 1'b1, 1'b1, 2'd2, 1'b0, 7'd5, 2, 4, -1, -1, w);
      do_txn("prio_data", 1'b0, 1'b0, 2'd0, 1'b0, 7'd5, 2, 3, -1, -1, w);
      total++;
      if (w != 0) begin
         bad++;
         $display("FAIL prio_data grant delay after FIN: got %0d want 0", w);
      end
   endtask

   task automatic test_packets();
      int w;
      do_txn("data_empty", 1'b0, 1'b0, 2'd0, 1'b0, 7'd0,  1, 2, -1, -1, w);
      do_txn("data_64",    1'b0, 1'b0, 2'd0, 1'b0, 7'd64, 1, 2, -1, -1, w);
      do_txn("data_stall", 1'b0, 1'b0, 2'd0, 1'b1, 7'd64, 1, 2, -1, -1, w);
      do_txn("hs_pid0",    1'b1, 1'b0, 2'd0, 1'b0, 7'd0,  1, 2, -1, -1, w);
      do_txn("hs_stall",   1'b1, 1'b0, 2'd3, 1'b0, 7'd0,  1, 2, -1, -1, w);
   endtask

   task automatic test_timeout();
      int w;
      do_txn("timeout", 1'b0, 1'b0, 2'd0, 1'b0, 7'd9, 1000, 0, -1, -1, w);
      do_txn("late_act", 1'b1, 1'b0, 2'd1, 1'b0, 7'd0, TMO, 2, -1, -1, w);
   endtask

   task automatic test_error();
      int w;
      do_txn("err_mid",   1'b1, 1'b0, 2'd1, 1'b0, 7'd0, 4, 8, 3, -1, w);
      do_txn("err_clean", 1'b0, 1'b0, 2'd0, 1'b0, 7'd20, 4, 8, -1, -1, w);
   endtask

   task automatic test_reset_abort();
      int w;
      do_txn("abort_gap",    1'b1, 1'b0, 2'd1, 1'b0, 7'd0, 2, 10, -1, 5, w);
      do_txn("abort_active", 1'b0, 1'b0, 2'd0, 1'b0, 7'd3, 2, 10, -1, GAP + 1 + 2 + 4, w);
      do_txn("after_abort",  1'b0, 1'b0, 2'd0, 1'b0, 7'd3, 2, 5, -1, -1, w);
   endtask

   task automatic test_random();
      int w, d, len, err_off;
      bit use_hs, stall;
      logic [1:0] pid;
      logic [6:0] occ;
      for (int i = 0; i < 12; i++) begin
         use_hs  = 1'($urandom_range(0, 1));
         pid     = 2'($urandom_range(0, 3));
         stall   = ($urandom_range(0, 3) == 0);
         occ     = ($urandom_range(0, 2) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
         d       = $urandom_range(1, 40);
         len     = $urandom_range(1, 12);
         err_off = ($urandom_range(0, 2) == 0 && d <= TMO) ? $urandom_range(0, len) : -1;
         repeat ($urandom_range(0, 3)) next_cycle();
         do_txn($sformatf("rand%0d", i), use_hs, 1'b0, pid, stall, occ, d, len, err_off, -1, w);
      end
   endtask

   initial begin
      idle_inputs();
      n_rst = 1'b0;
      test_reset();
      test_hs_basic();
      test_priority();
      test_packets();
      test_timeout();
      test_error();
      test_reset_abort();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
